rans_freq_table: RTL and testbench

//  Programmable symbol-statistics stage directly upstream of the rANS encoder core.

---
 rtl/rans_freq_table.sv | 245 ++++++++++++++++++++++++
 tb/tb_rans_freq_table.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rans_freq_table.sv
`default_nettype none
// ============================================================================
//  Module      : rans_freq_table
//  Description : Programmable symbol-statistics table feeding the rANS encoder.
//                A normalised frequency table is streamed in (cumulative
//                frequencies are built on the fly and the total is checked),
//                then a valid/ready symbol stream is mapped to
//                (freq, cum_freq) result beats through a 2-stage pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
module rans_freq_table #(
    parameter int RESOLUTION   = 10,
    parameter int SYMBOL_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // table load interface
    input  logic                    load_start,
    input  logic                    load_valid,
    input  logic [RESOLUTION:0]     load_freq,
    output logic                    load_ready,
    output logic                    table_ready,
    output logic                    table_err,
    // lookup request stream
    input  logic                    sym_valid,
    input  logic [SYMBOL_WIDTH-1:0] sym,
    input  logic                    sym_last,
    output logic                    sym_ready,
    // lookup result stream
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SYMBOL_WIDTH-1:0] out_sym,
    output logic [RESOLUTION:0]     out_freq,
    output logic [RESOLUTION-1:0]   out_cum,
    output logic                    out_zero,
    output logic                    out_last
);

    localparam int c_depth = 2 ** SYMBOL_WIDTH;
    // Accumulator is wide enough that N entries of the maximum freq never wrap
    localparam int c_sum_w = RESOLUTION + SYMBOL_WIDTH + 1;
    // One table entry: {freq, low RESOLUTION bits of cum_freq}
    localparam int c_ent_w = 2 * RESOLUTION + 1;
    localparam logic [SYMBOL_WIDTH-1:0] c_last_idx = '1;
    localparam logic [c_sum_w-1:0]      c_total    = c_sum_w'(1) << RESOLUTION;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_LOAD  = 3'd2,
        ST_CHECK = 3'd3,
        ST_READY = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    // load-side state
    logic [SYMBOL_WIDTH-1:0] r_idx;
    logic [c_sum_w-1:0]      r_sum;
    logic                    r_table_ready;
    logic                    r_table_err;

    // table storage and its registered read port
    logic [c_ent_w-1:0]      r_ram [c_depth];
    logic [c_ent_w-1:0]      r_ram_q;

    // pipeline stage 1 (RAM read in flight) and its stall hold register
    logic                    r_s1_valid;
    logic [SYMBOL_WIDTH-1:0] r_s1_sym;
    logic                    r_s1_last;
    logic                    r_hold_valid;
    logic [c_ent_w-1:0]      r_hold;

    // pipeline stage 2 (output register)
    logic                    r_s2_valid;
    logic [SYMBOL_WIDTH-1:0] r_s2_sym;
    logic [RESOLUTION:0]     r_s2_freq;
    logic [RESOLUTION-1:0]   r_s2_cum;
    logic                    r_s2_zero;
    logic                    r_s2_last;

    logic                    w_load_fire;
    logic                    w_load_begin;
    logic                    w_enter_load;
    logic [c_sum_w-1:0]      w_freq_ext;
    logic                    w_pipe_empty;
    logic                    w_s2_stall;
    logic                    w_s1_adv;
    logic                    w_sym_fire;
    logic [c_ent_w-1:0]      w_s1_data;
    logic [RESOLUTION:0]     w_s1_freq;

    // A load_start in LOAD restarts the table, so the beat presented in that
    // same cycle is refused rather than written at a stale index.
    assign load_ready   = (r_state == ST_LOAD) && !load_start;
    assign w_load_fire  = load_valid && load_ready;
    assign w_freq_ext   = {{(c_sum_w - RESOLUTION - 1){1'b0}}, load_freq};

    // Index/accumulator clear on every (re)start of a load
    assign w_enter_load = (w_next_state == ST_LOAD) && (r_state != ST_LOAD);
    assign w_load_begin = w_enter_load || ((r_state == ST_LOAD) && load_start);

    assign w_pipe_empty = !r_s1_valid && !r_s2_valid;
    assign w_s2_stall   = r_s2_valid && !out_ready;
    assign w_s1_adv     = r_s1_valid && !w_s2_stall;
    assign sym_ready    = (r_state == ST_READY) && !(r_s1_valid && w_s2_stall);
    assign w_sym_fire   = sym_valid && sym_ready;

    // The RAM output is only meaningful the cycle after the read, so a
    // stalled stage 1 takes its data from the hold register instead.
    assign w_s1_data    = r_hold_valid ? r_hold : r_ram_q;
    assign w_s1_freq    = w_s1_data[c_ent_w-1 -: RESOLUTION+1];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (load_start) w_next_state = ST_LOAD;
            end
            ST_READY: begin
                if (load_start) w_next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                // in-flight lookups must finish against the old table
                if (w_pipe_empty) w_next_state = ST_LOAD;
            end
            ST_LOAD: begin
                if (w_load_fire && (r_idx == c_last_idx)) w_next_state = ST_CHECK;
            end
            ST_CHECK: begin
                w_next_state = (r_sum == c_total) ? ST_READY : ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Load accumulator, index and table status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx         <= '0;
            r_sum         <= '0;
            r_table_ready <= 1'b0;
            r_table_err   <= 1'b0;
        end else begin
            if (w_load_begin) begin
                r_idx <= '0;
                r_sum <= '0;
            end else if (w_load_fire) begin
                r_idx <= r_idx + SYMBOL_WIDTH'(1);
                r_sum <= r_sum + w_freq_ext;
            end

            if (w_enter_load) begin
                r_table_ready <= 1'b0;
                r_table_err   <= 1'b0;
            end else if (r_state == ST_CHECK) begin
                if (r_sum == c_total) begin
                    r_table_ready <= 1'b1;
                end else begin
                    r_table_err   <= 1'b1;
                end
            end
        end
    end

    assign table_ready = r_table_ready;
    assign table_err   = r_table_err;

    // Table RAM: write port driven by the load stream, read port every cycle.
    // Contents are not reset; the table is invalid until a load passes CHECK.
    always_ff @(posedge clk) begin
        if (w_load_fire) begin
            r_ram[r_idx] <= {load_freq, r_sum[RESOLUTION-1:0]};
        end
        r_ram_q <= r_ram[sym];
    end

    // Lookup pipeline: stage 1 tracking, stall hold register, output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_sym     <= '0;
            r_s1_last    <= 1'b0;
            r_hold_valid <= 1'b0;
            r_hold       <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_sym     <= '0;
            r_s2_freq    <= '0;
            r_s2_cum     <= '0;
            r_s2_zero    <= 1'b0;
            r_s2_last    <= 1'b0;
        end else begin
            // stage 1 fills on a handshake and empties when stage 2 takes it
            if (w_sym_fire) begin
                r_s1_valid <= 1'b1;
                r_s1_sym   <= sym;
                r_s1_last  <= sym_last;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end

            // capture RAM data on the first stalled cycle, release on advance
            if (w_s1_adv || w_sym_fire) begin
                r_hold_valid <= 1'b0;
            end else if (r_s1_valid && !r_hold_valid) begin
                r_hold_valid <= 1'b1;
                r_hold       <= r_ram_q;
            end

            // output stage holds its contents while the encoder stalls
            if (!w_s2_stall) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_sym  <= r_s1_sym;
                    r_s2_freq <= w_s1_freq;
                    r_s2_cum  <= w_s1_data[RESOLUTION-1:0];
                    r_s2_zero <= (w_s1_freq == '0);
                    r_s2_last <= r_s1_last;
                end
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_sym   = r_s2_sym;
    assign out_freq  = r_s2_freq;
    assign out_cum   = r_s2_cum;
    assign out_zero  = r_s2_zero;
    assign out_last  = r_s2_last;

endmodule
`default_nettype wire

// File: tb/tb_rans_freq_table.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rans_freq_table
//  Description : Self-checking bench for rans_freq_table. Directed load and
//                lookup steps; a scoreboard queue receives the expected result
//                at each symbol handshake and is compared at each result beat.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rans_freq_table;

    localparam int RES = 10;
    localparam int SW  = 8;
    localparam int N   = 256;

    typedef struct packed {
        logic [SW-1:0] sym;
        logic [RES:0]  freq;
        logic [RES-1:0] cum;
        logic          zero;
        logic          last;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           load_start = 1'b0;
    logic           load_valid = 1'b0;
    logic [RES:0]   load_freq = '0;
    logic           load_ready;
    logic           table_ready;
    logic           table_err;
    logic           sym_valid = 1'b0;
    logic [SW-1:0]  sym = '0;
    logic           sym_last = 1'b0;
    logic           sym_ready;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [SW-1:0]  out_sym;
    logic [RES:0]   out_freq;
    logic [RES-1:0] out_cum;
    logic           out_zero;
    logic           out_last;

    int   total = 0;
    int   bad = 0;
    int   n_delivered = 0;
    exp_t sb[$];
    logic [RES:0] tb_freq [N];   // model of the table currently in force
    logic [RES:0] ld_freq [N];   // table being streamed in
    exp_t mon_cur;
    exp_t mon_prev;
    exp_t mon_exp;
    logic stall_prev = 1'b0;

    rans_freq_table #(
        .RESOLUTION   (RES),
        .SYMBOL_WIDTH (SW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_freq   (load_freq),
        .load_ready  (load_ready),
        .table_ready (table_ready),
        .table_err   (table_err),
        .sym_valid   (sym_valid),
        .sym         (sym),
        .sym_last    (sym_last),
        .sym_ready   (sym_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sym     (out_sym),
        .out_freq    (out_freq),
        .out_cum     (out_cum),
        .out_zero    (out_zero),
        .out_last    (out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [RES-1:0] cum_of(input int s);
        int acc;
        logic [31:0] a;
        acc = 0;
        for (int i = 0; i < s; i++) acc += int'(tb_freq[i]);
        a = acc;
        return a[RES-1:0];
    endfunction

    // Result monitor: stability while stalled, scoreboard pop/compare, and
    // expected-result push at each accepted request.
    always @(negedge clk) begin
        mon_cur = {out_sym, out_freq, out_cum, out_zero, out_last};
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                total++;
                assert (out_valid === 1'b1 && mon_cur === mon_prev) else begin
                    bad++;
                    $error("FAIL stall_stable: observed=%h/%0b expected=%h/1", mon_cur, out_valid, mon_prev);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $error("FAIL unexpected_result: observed=%h expected=none", mon_cur);
                end else begin
                    mon_exp = sb.pop_front();
                    n_delivered++;
                    assert (mon_cur === mon_exp) else begin
                        bad++;
                        $error("FAIL result: observed=%h expected=%h", mon_cur, mon_exp);
                    end
                end
            end
            if (sym_valid && sym_ready) begin
                mon_exp.sym  = sym;
                mon_exp.freq = tb_freq[sym];
                mon_exp.cum  = cum_of(int'(sym));
                mon_exp.zero = (tb_freq[sym] == '0);
                mon_exp.last = sym_last;
                sb.push_back(mon_exp);
            end
            stall_prev = out_valid && !out_ready;
            mon_prev   = mon_cur;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic load_table(input int n_beats);
        int w;
        for (int i = 0; i < n_beats; i++) begin
            load_valid = 1'b1;
            load_freq  = ld_freq[i];
            w = 0;
            @(negedge clk);
            while (!load_ready && w < 50) begin
                w++;
                @(negedge clk);
            end
            if (!load_ready) begin
                check("load_ready_timeout", 64'(load_ready), 64'd1);
                break;
            end
            tick();
        end
        load_valid = 1'b0;
    endtask

    // Called right after the last beat's edge: CHECK cycle, then READY.
    task automatic finish_good_load();
        @(negedge clk);
        check("check_cycle_not_ready", 64'(table_ready), 64'd0);
        tick();
        @(negedge clk);
        check("table_ready_after_load", {table_ready, table_err}, 64'b10);
        tick();
        for (int i = 0; i < N; i++) tb_freq[i] = ld_freq[i];
    endtask

    task automatic good_load();
        pulse_load_start();
        @(negedge clk);
        check("err_clear_on_start", 64'(table_err), 64'd0);
        tick();
        load_table(N);
        finish_good_load();
    endtask

    task automatic send_sym(input logic [SW-1:0] s, input logic l);
        int w;
        sym_valid = 1'b1;
        sym       = s;
        sym_last  = l;
        w = 0;
        @(negedge clk);
        while (!sym_ready && w < 100) begin
            w++;
            @(negedge clk);
        end
        if (!sym_ready) check("sym_ready_timeout", 64'(sym_ready), 64'd1);
        tick();
        sym_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while ((sb.size() != 0 || out_valid) && w < 200) begin
            w++;
            @(negedge clk);
        end
        check("drain", 64'(sb.size()), 64'd0);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int w;
        logic seen;

        for (int i = 0; i < N; i++) tb_freq[i] = '0;

        // ---- reset state
        repeat (2) tick();
        check("reset_outputs",
              {load_ready, table_ready, table_err, sym_ready, out_valid,
               out_sym, out_freq, out_cum, out_zero, out_last}, 64'd0);
        rst_n = 1'b1;
        tick();

        // ---- 1: uniform table, freq 4 everywhere, then lookup 0x05
        for (int i = 0; i < N; i++) ld_freq[i] = 11'd4;
        good_load();
        send_sym(8'h05, 1'b0);
        @(negedge clk);
        check("t1_latency_s1", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("t1_result", {out_valid, out_freq, out_cum}, {1'b1, 11'd4, 10'd20});
        wait_drain();

        // ---- 3: stream 0..9, out_ready low for cycles 3..12
        d0 = n_delivered;
        fork
            begin
                for (int s = 0; s < 10; s++) send_sym(8'(s), (s == 9));
            end
            begin
                repeat (2) tick();
                out_ready = 1'b0;
                repeat (10) tick();
                out_ready = 1'b1;
            end
        join
        wait_drain();
        check("t3_count", 64'(n_delivered - d0), 64'd10);

        // ---- 2: bad total (1025) sets table_err, blocks lookups
        ld_freq[0] = 11'd5;
        pulse_load_start();
        load_table(N);
        @(negedge clk);
        check("t2_check_cycle", {table_ready, table_err}, 64'd0);
        tick();
        @(negedge clk);
        check("t2_err", {table_ready, table_err}, 64'b01);
        tick();
        sym_valid = 1'b1;
        sym       = 8'h01;
        seen      = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (sym_ready) seen = 1'b1;
        end
        check("t2_sym_ready_low", 64'(seen), 64'd0);
        tick();
        sym_valid = 1'b0;
        ld_freq[0] = 11'd4;
        good_load();
        send_sym(8'hff, 1'b1);
        wait_drain();

        // ---- 5: load_start with two results stalled in the pipeline
        d0 = n_delivered;
        out_ready = 1'b0;
        send_sym(8'd10, 1'b0);
        send_sym(8'd11, 1'b1);
        pulse_load_start();
        sym_valid = 1'b1;
        sym       = 8'd12;
        sym_last  = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("t5_stall_ready", {sym_ready, load_ready}, 64'd0);
        end
        tick();
        out_ready = 1'b1;
        w    = 0;
        seen = 1'b0;
        @(negedge clk);
        while (!load_ready && w < 50) begin
            if (sym_ready) seen = 1'b1;
            w++;
            @(negedge clk);
        end
        check("t5_load_entered", 64'(load_ready), 64'd1);
        check("t5_sym_ready_low", 64'(seen), 64'd0);
        check("t5_delivered", 64'(n_delivered - d0), 64'd2);
        check("t5_table_ready_cleared", 64'(table_ready), 64'd0);
        tick();
        sym_valid = 1'b0;
        // continue this load with the single-symbol table
        for (int i = 0; i < N; i++) ld_freq[i] = '0;
        ld_freq[7] = 11'd1024;
        load_table(N);
        finish_good_load();

        // ---- 4: freq[7]=1024, all others zero
        d0 = n_delivered;
        send_sym(8'd7, 1'b0);
        send_sym(8'd8, 1'b0);
        send_sym(8'd3, 1'b1);
        wait_drain();
        check("t4_count", 64'(n_delivered - d0), 64'd3);

        // ---- 6: reset in the middle of a load
        for (int i = 0; i < N; i++) ld_freq[i] = 11'd4;
        pulse_load_start();
        load_table(100);
        load_valid = 1'b1;
        load_freq  = ld_freq[100];
        rst_n      = 1'b0;
        #1;
        check("t6_async_reset",
              {load_ready, table_ready, table_err, sym_ready, out_valid,
               out_sym, out_freq, out_cum, out_zero, out_last}, 64'd0);
        load_valid = 1'b0;
        repeat (2) tick();
        rst_n     = 1'b1;
        sym_valid = 1'b1;
        sym       = 8'h02;
        repeat (3) begin
            @(negedge clk);
            check("t6_after_release", {table_ready, load_ready, sym_ready, out_valid}, 64'd0);
        end
        tick();
        sym_valid = 1'b0;
        good_load();
        d0 = n_delivered;
        send_sym(8'h05, 1'b0);
        send_sym(8'hff, 1'b1);
        wait_drain();
        check("t6_count", 64'(n_delivered - d0), 64'd2);
        check("final_idle", {out_valid, 32'(sb.size())}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
